// File: rtl/game_status_ctrl.sv
// Game status controller: IDLE/PLAY/PAUSE/LOST sequencing, collision detection and scoring.
// Define HIGH_SCORE_EN to keep a best score across games; otherwise highest_score is tied to 0.
module game_status_ctrl #(
  parameter int unsigned BIRD_X    = 160,
  parameter int unsigned BIRD_W    = 16,
  parameter int unsigned BIRD_H    = 16,
  parameter int unsigned PILLAR_W  = 40,
  parameter int unsigned GAP_H     = 120,
  parameter int unsigned FLOOR_Y   = 464,
  parameter int unsigned MAX_SCORE = 999,
  parameter int unsigned LOST_HOLD = 50
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       paused,
  input  logic [9:0] bird_y,
  input  logic [8:0] pillar1_x,
  input  logic [8:0] pillar2_x,
  input  logic [9:0] gap1_y,
  input  logic [9:0] gap2_y,
  output logic [1:0] game_state,
  output logic [9:0] current_score,
  output logic [9:0] highest_score,
  output logic       lost,
  output logic       run_en
);

  localparam int unsigned HoldW = $clog2(LOST_HOLD + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StPause = 2'd2,
    StLost  = 2'd3
  } state_e;

  state_e           state_q;
  logic             start_q;
  logic [8:0]       prev1_x_q, prev2_x_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [9:0]       score_q;

  logic             start_edge;
  logic             collision;
  logic             pass1, pass2;
  logic [10:0]      score_sum;
  logic [9:0]       score_next;

  // All geometry is widened to 11 bits so edge sums never wrap.
  function automatic logic pillar_hit(input logic [8:0] px, input logic [9:0] gy,
                                      input logic [9:0] by);
    logic [10:0] left;
    logic        overlap;
    logic        outside_gap;
    left        = 11'(px);
    overlap     = (11'(BIRD_X) < left + 11'(PILLAR_W)) && (left < 11'(BIRD_X) + 11'(BIRD_W));
    outside_gap = (11'(by) < 11'(gy)) || (11'(by) + 11'(BIRD_H) > 11'(gy) + 11'(GAP_H));
    return overlap && outside_gap;
  endfunction

  // A pillar moving right means it wrapped to the far side; never a pass.
  function automatic logic pillar_pass(input logic [8:0] prev_x, input logic [8:0] cur_x);
    return (11'(prev_x) + 11'(PILLAR_W) >= 11'(BIRD_X)) &&
           (11'(cur_x) + 11'(PILLAR_W) < 11'(BIRD_X)) &&
           !(cur_x > prev_x);
  endfunction

  always_comb begin
    start_edge = start && !start_q;
    collision  = (bird_y == 10'd0) ||
                 (11'(bird_y) + 11'(BIRD_H) >= 11'(FLOOR_Y)) ||
                 pillar_hit(pillar1_x, gap1_y, bird_y) ||
                 pillar_hit(pillar2_x, gap2_y, bird_y);
    pass1      = pillar_pass(prev1_x_q, pillar1_x);
    pass2      = pillar_pass(prev2_x_q, pillar2_x);
    score_sum  = 11'(score_q) + 11'(pass1) + 11'(pass2);
    score_next = (score_sum > 11'(MAX_SCORE)) ? 10'(MAX_SCORE) : score_sum[9:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= StIdle;
      start_q    <= 1'b1;
      prev1_x_q  <= '0;
      prev2_x_q  <= '0;
      hold_cnt_q <= '0;
      score_q    <= '0;
    end else begin
      start_q   <= start;
      prev1_x_q <= pillar1_x;
      prev2_x_q <= pillar2_x;
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q <= StPlay;
            score_q <= '0;
          end
        end
        StPlay: begin
          if (collision) begin
            state_q    <= StLost;
            hold_cnt_q <= '0;
          end else begin
            score_q <= score_next;
            if (paused) state_q <= StPause;
          end
        end
        StPause: begin
          if (!paused) state_q <= StPlay;
        end
        StLost: begin
          if (hold_cnt_q < HoldW'(LOST_HOLD)) hold_cnt_q <= hold_cnt_q + 1'b1;
          if (start_edge && (hold_cnt_q >= HoldW'(LOST_HOLD))) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HIGH_SCORE_EN
  logic [9:0] best_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      best_q <= '0;
    end else if ((state_q == StPlay) && collision && (score_q > best_q)) begin
      best_q <= score_q;
    end
  end

  assign highest_score = best_q;
`else
  assign highest_score = '0;
`endif

  assign game_state    = state_q;
  assign current_score = score_q;
  assign lost          = (state_q == StLost);
  assign run_en        = (state_q == StPlay);

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl: reset, passes, saturation, pause, collision, hold, wrap, floor.
module tb_game_status_ctrl;

  logic       clk = 1'b0;
  logic       clr, start, paused;
  logic [9:0] bird_y, gap1_y, gap2_y;
  logic [8:0] pillar1_x, pillar2_x;
  logic [1:0] game_state;
  logic [9:0] current_score, highest_score;
  logic       lost, run_en;

  int vectors    = 0;
  int miscompares = 0;
  int exp_best;

  game_status_ctrl dut (
    .clk           (clk),
    .clr           (clr),
    .start         (start),
    .paused        (paused),
    .bird_y        (bird_y),
    .pillar1_x     (pillar1_x),
    .pillar2_x     (pillar2_x),
    .gap1_y        (gap1_y),
    .gap2_y        (gap2_y),
    .game_state    (game_state),
    .current_score (current_score),
    .highest_score (highest_score),
    .lost          (lost),
    .run_en        (run_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef HIGH_SCORE_EN
    exp_best = 999;
`else
    exp_best = 0;
`endif
    clr = 1'b1; start = 1'b1; paused = 1'b0;
    bird_y = 10'd200; gap1_y = 10'd180; gap2_y = 10'd180;
    pillar1_x = 9'd400; pillar2_x = 9'd400;
    tick(); tick();
    chk("rst_state", int'(game_state), 0);
    chk("rst_score", int'(current_score), 0);
    chk("rst_best", int'(highest_score), 0);
    chk("rst_lost", int'(lost), 0);
    chk("rst_run_en", int'(run_en), 0);

    // Button held through reset release gives no edge
    clr = 1'b0;
    tick();
    chk("held_start_no_edge", int'(game_state), 0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("start_play", int'(game_state), 1);
    chk("start_run_en", int'(run_en), 1);
    chk("start_score", int'(current_score), 0);
    start = 1'b0;

    // Single pass: right edge 161 -> 159 across 160
    pillar1_x = 9'd121; tick();
    chk("overlap_in_gap", int'(game_state), 1);
    pillar1_x = 9'd119; tick();
    chk("single_pass", int'(current_score), 1);

    pillar1_x = 9'd121; pillar2_x = 9'd121; tick();
    pillar1_x = 9'd119; pillar2_x = 9'd119; tick();
    chk("double_pass", int'(current_score), 3);

    pillar1_x = 9'd121; tick();
    pillar1_x = 9'd119; tick();
    for (int i = 0; i < 497; i++) begin
      pillar1_x = 9'd121; pillar2_x = 9'd121; tick();
      pillar1_x = 9'd119; pillar2_x = 9'd119; tick();
    end
    chk("score_998", int'(current_score), 998);
    pillar1_x = 9'd121; pillar2_x = 9'd121; tick();
    pillar1_x = 9'd119; pillar2_x = 9'd119; tick();
    chk("saturate_999", int'(current_score), 999);
    pillar1_x = 9'd121; pillar2_x = 9'd121; tick();
    pillar1_x = 9'd119; pillar2_x = 9'd119; tick();
    chk("saturate_hold", int'(current_score), 999);

    // Pause: no collision or scoring while paused
    paused = 1'b1; tick();
    chk("pause_state", int'(game_state), 2);
    chk("pause_run_en", int'(run_en), 0);
    bird_y = 10'd0; tick();
    chk("pause_ignores_collision", int'(game_state), 2);
    bird_y = 10'd200; paused = 1'b0; tick();
    chk("resume_play", int'(game_state), 1);

    // Collision beats pause
    pillar1_x = 9'd150; pillar2_x = 9'd400; bird_y = 10'd100; paused = 1'b1;
    #2;
    chk("collision_not_yet", int'(game_state), 1);
    tick();
    chk("collision_state", int'(game_state), 3);
    chk("collision_lost", int'(lost), 1);
    chk("collision_score", int'(current_score), 999);
    chk("collision_best", int'(highest_score), exp_best);

    // Lost hold
    pillar1_x = 9'd400; bird_y = 10'd200; paused = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    start = 1'b1; tick();
    chk("early_edge_ignored", int'(game_state), 3);
    start = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    start = 1'b1; tick();
    chk("hold_release_idle", int'(game_state), 0);
    chk("idle_score_hold", int'(current_score), 999);
    start = 1'b0; pillar1_x = 9'd100; tick();
    start = 1'b1; tick();
    chk("replay_state", int'(game_state), 1);
    chk("replay_score_clr", int'(current_score), 0);
    chk("replay_best_kept", int'(highest_score), exp_best);
    start = 1'b0;

    // Wrap-around never scores
    pillar1_x = 9'd0; tick();
    pillar1_x = 9'd500; tick();
    chk("wrap_no_score", int'(current_score), 0);
    pillar1_x = 9'd400; tick();
    pillar1_x = 9'd121; tick();
    pillar1_x = 9'd119; tick();
    chk("pass_after_replay", int'(current_score), 1);

    // Floor boundary: 447+16 = 463 is safe, 448+16 = 464 collides
    bird_y = 10'd447; tick();
    chk("floor_minus_one", int'(game_state), 1);
    bird_y = 10'd448; tick();
    chk("floor_lost", int'(game_state), 3);
    chk("floor_best_kept", int'(highest_score), exp_best);

    // Mid-game clr
    clr = 1'b1; tick();
    chk("clr_state", int'(game_state), 0);
    chk("clr_best", int'(highest_score), 0);
    chk("clr_score", int'(current_score), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
